// File: rtl/imm_encoder.sv
// imm_encoder: packs format/opcode/register/funct/immediate fields into an
// RV32I instruction word. Two-stage valid/ready pipeline: S1 holds the raw
// request and validates the immediate, S2 holds the packed word.
module imm_encoder #(
  parameter bit CHECK_RANGE = 1'b1,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         imm_sel,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [31:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic               out_err,
  output logic [1:0]         err_code,
  output logic [COUNT_W-1:0] enc_count
);

  // format select codes shared with the decode side
  localparam logic [2:0] I_TYPE = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] B_TYPE = 3'd2;
  localparam logic [2:0] U_TYPE = 3'd3;
  localparam logic [2:0] J_TYPE = 3'd4;

  localparam logic [1:0]  ERR_OK    = 2'b00;
  localparam logic [1:0]  ERR_RANGE = 2'b01;
  localparam logic [1:0]  ERR_ALIGN = 2'b10;
  localparam logic [1:0]  ERR_SEL   = 2'b11;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          STAGES    = 2;

  typedef struct packed {
    logic [2:0]  sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } enc_req_t;

  enc_req_t          s1_req;
  logic [STAGES:1]   vld_pipe;
  logic              s1_valid, s2_valid, s2_adv, in_fire;
  logic [1:0]        s1_err;
  logic [31:0]       s1_word;
  logic              fit11, fit12, fit20;

  assign s1_valid  = vld_pipe[1];
  assign s2_valid  = vld_pipe[2];
  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // sign-extension checks: the dropped upper bits must all match the kept sign bit
  assign fit11 = (&s1_req.imm[31:11]) || !(|s1_req.imm[31:11]);
  assign fit12 = (&s1_req.imm[31:12]) || !(|s1_req.imm[31:12]);
  assign fit20 = (&s1_req.imm[31:20]) || !(|s1_req.imm[31:20]);

  // classify the S1 immediate; bad select beats misalignment beats range
  always_comb begin
    s1_err = ERR_OK;
    case (s1_req.sel)
      I_TYPE, S_TYPE: if (CHECK_RANGE && !fit11) s1_err = ERR_RANGE;
      B_TYPE: begin
        if (CHECK_RANGE && s1_req.imm[0]) s1_err = ERR_ALIGN;
        else if (CHECK_RANGE && !fit12)   s1_err = ERR_RANGE;
      end
      J_TYPE: begin
        if (CHECK_RANGE && s1_req.imm[0]) s1_err = ERR_ALIGN;
        else if (CHECK_RANGE && !fit20)   s1_err = ERR_RANGE;
      end
      U_TYPE: if (CHECK_RANGE && (s1_req.imm[11:0] != 12'h000)) s1_err = ERR_RANGE;
      default: s1_err = ERR_SEL;
    endcase
  end

  // scatter immediate bits into the format's fixed positions; errors emit a NOP
  always_comb begin
    s1_word = NOP;
    case (s1_req.sel)
      I_TYPE: s1_word = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3, s1_req.rd, s1_req.opcode};
      S_TYPE: s1_word = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1, s1_req.funct3,
                         s1_req.imm[4:0], s1_req.opcode};
      B_TYPE: s1_word = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2, s1_req.rs1,
                         s1_req.funct3, s1_req.imm[4:1], s1_req.imm[11], s1_req.opcode};
      U_TYPE: s1_word = {s1_req.imm[31:12], s1_req.rd, s1_req.opcode};
      J_TYPE: s1_word = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11],
                         s1_req.imm[19:12], s1_req.rd, s1_req.opcode};
      default: s1_word = NOP;
    endcase
    if (s1_err != ERR_OK) s1_word = NOP;
  end

  // stage occupancy: S1 refills on accept, S2 takes S1 whenever it may advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_fire || (s1_valid && !s2_adv);
      if (s2_adv) vld_pipe[2] <= s1_valid;
    end
  end

  // S1 request capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        s1_req <= '0;
    else if (in_fire) s1_req <= '{sel: imm_sel, opcode: opcode, rd: rd, rs1: rs1,
                                  rs2: rs2, funct3: funct3, imm: imm};
  end

  // S2 output word; held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= '0;
      out_err  <= 1'b0;
      err_code <= ERR_OK;
    end else if (s1_valid && s2_adv) begin
      instr    <= s1_word;
      out_err  <= (s1_err != ERR_OK);
      err_code <= s1_err;
    end
  end

  // saturating count of clean words handed to the consumer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      enc_count <= '0;
    else if (out_valid && out_ready && !out_err && (enc_count != {COUNT_W{1'b1}}))
      enc_count <= enc_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encodings, error codes, stall/backpressure
// ordering and mid-flight reset, against hand-computed words.
module tb_imm_encoder;

  localparam logic [2:0] I_T = 3'd0, S_T = 3'd1, B_T = 3'd2, U_T = 3'd3, J_T = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  imm_sel;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] instr;
  logic        out_err;
  logic [1:0]  err_code;
  logic [15:0] enc_count;

  int checks   = 0;
  int failures = 0;

  imm_encoder #(.CHECK_RANGE(1'b1), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .out_err(out_err), .err_code(err_code), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                         input logic [31:0] im);
    imm_sel = s; opcode = op; rd = d; rs1 = r1; rs2 = r2; funct3 = f3; imm = im;
  endtask

  // one request through an idle pipe with the consumer always ready
  task automatic send_one(input string tag, input logic [2:0] s, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [2:0] f3, input logic [31:0] im,
                          input logic [31:0] exp_instr, input logic [1:0] exp_code);
    int lat;
    int waits;
    @(negedge clk);
    out_ready = 1'b1;
    set_req(s, op, d, r1, r2, f3, im);
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk({tag, "_latency"}, lat, 32'd2);
    chk({tag, "_instr"}, instr, exp_instr);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_code != 2'b00});
    chk({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_w [4];
  int nsent, ncol;

  initial begin
    exp_w[0] = 32'h0001_0093;
    exp_w[1] = 32'h0011_0113;
    exp_w[2] = 32'h0021_0193;
    exp_w[3] = 32'h0031_0213;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_req(I_T, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {29'd0, out_err, err_code}, 32'd0);
    chk("rst_count", {16'd0, enc_count}, 32'd0);
    reset = 1'b0;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // field packing for every format
    send_one("i_neg1", I_T, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'b00);
    chk("cnt_after_i", {16'd0, enc_count}, 32'd1);
    send_one("s_sw", S_T, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423, 2'b00);
    send_one("b_m4", B_T, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'b00);
    send_one("j_800", J_T, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'h0010_00EF, 2'b00);
    send_one("u_lui", U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 2'b00);
    chk("cnt_after_ok", {16'd0, enc_count}, 32'd5);

    // error words come out as NOPs and are not counted
    send_one("b_misal", B_T, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0000_0013, 2'b10);
    send_one("i_range", I_T, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0000_0013, 2'b01);
    send_one("bad_sel", 3'b111, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0000_0013, 2'b11);
    send_one("u_low", U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h0000_0013, 2'b01);
    send_one("j_range", J_T, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000, 32'h0000_0013, 2'b01);
    chk("cnt_after_err", {16'd0, enc_count}, 32'd5);

    // back-to-back stream with the consumer stalled for the first words
    nsent = 0;
    ncol = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (nsent < 4) begin
        in_valid = 1'b1;
        set_req(I_T, 7'h13, 5'(nsent + 1), 5'd2, 5'd0, 3'd0, 32'(nsent));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) chk("stream_accepts", nsent, 32'd2);
      if (cyc >= 2 && cyc <= 4) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_instr", instr, exp_w[0]);
      end
      if (out_valid && out_ready) begin
        if (ncol < 4) chk("stream_word", instr, exp_w[ncol]);
        else          chk("stream_extra", 32'd1, 32'd0);
        ncol++;
      end
      if (in_valid && in_ready) nsent++;
    end
    in_valid = 1'b0;
    chk("stream_sent", nsent, 32'd4);
    chk("stream_count", ncol, 32'd4);
    chk("cnt_after_stream", {16'd0, enc_count}, 32'd9);

    // fill both stages, then reset while they are occupied
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_req(I_T, 7'h13, 5'(k + 1), 5'd2, 5'd0, 3'd0, 32'(k));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_count", {16'd0, enc_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("post_rst_no_word", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
